// File: rtl/imem_boot_sequencer_if.sv
// Program-word stream from the host loader into imem_boot_sequencer.
// Valid/ready handshake: a word transfers on a rising edge with s_valid & s_ready.
interface imem_boot_sequencer_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/imem_boot_sequencer.sv
// Boot sequencer for the single-cycle cpu: hold in reset, load imem, settle, run, halt.
// Optional BOOT_CHECKSUM_EN adds expected_sum and a load-checksum gate before SETTLE.
module imem_boot_sequencer #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned MAX_WORDS     = 64,
  parameter int unsigned WORD_CNT_W    = 8,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_CNT_W-1:0] load_count,
  input  logic [CNT_W-1:0]      run_limit,
`ifdef BOOT_CHECKSUM_EN
  input  logic [31:0]           expected_sum,
`endif
  imem_boot_sequencer_if.slave  s,
  output logic                  initialize,
  output logic [31:0]           init_data,
  output logic [31:0]           init_addr,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [WORD_CNT_W-1:0] idx_q, idx_d, load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0]      run_lim_q, run_lim_d, run_cnt_q, run_cnt_d;
  logic [31:0]           settle_cnt_q, settle_cnt_d;
  logic                  drain_q, drain_d;
  logic [31:0]           init_data_q, init_data_d, init_addr_q, init_addr_d;
  logic                  initialize_q, initialize_d, cpu_rst_q, cpu_rst_d;
  logic                  s_ready_q, s_ready_d, busy_q, busy_d;
  logic                  done_q, done_d, error_q, error_d;
  logic                  hs;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]           sum_q, sum_d, exp_q, exp_d;
`endif

  assign hs = s.s_valid & s_ready_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    load_cnt_d   = load_cnt_q;
    run_lim_d    = run_lim_q;
    run_cnt_d    = run_cnt_q;
    settle_cnt_d = settle_cnt_q;
    drain_d      = drain_q;
    init_data_d  = init_data_q;
    init_addr_d  = init_addr_q;
    initialize_d = 1'b0;
    error_d      = error_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d        = sum_q;
    exp_d        = exp_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (32'(load_count) > MAX_WORDS) begin
            error_d = 1'b1;
          end else begin
            error_d      = 1'b0;
            load_cnt_d   = load_count;
            run_lim_d    = run_limit;
            idx_d        = '0;
            run_cnt_d    = '0;
            settle_cnt_d = '0;
            drain_d      = 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum_d        = '0;
            exp_d        = expected_sum;
`endif
            if (load_count == '0) begin
`ifdef BOOT_CHECKSUM_EN
              if (expected_sum != '0) begin
                error_d = 1'b1;
                state_d = S_DONE;
              end else begin
                state_d = S_SETTLE;
              end
`else
              state_d = S_SETTLE;
`endif
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end
      S_LOAD: begin
        // drain_q marks the cycle the last word's write is on the bus; s_ready is already low.
        if (drain_q) begin
          drain_d = 1'b0;
`ifdef BOOT_CHECKSUM_EN
          if (sum_q != exp_q) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_SETTLE;
          end
`else
          state_d = S_SETTLE;
`endif
        end else if (hs) begin
          init_data_d  = s.s_data;
          init_addr_d  = BASE_ADDR + (32'(idx_q) << 2);
          initialize_d = 1'b1;
          idx_d        = idx_q + WORD_CNT_W'(1);
`ifdef BOOT_CHECKSUM_EN
          sum_d        = sum_q + s.s_data;
`endif
          if (idx_q == load_cnt_q - WORD_CNT_W'(1)) drain_d = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == 32'(SETTLE_CYCLES - 1)) begin
          settle_cnt_d = '0;
          run_cnt_d    = '0;
          state_d      = S_RUN;
        end else begin
          settle_cnt_d = settle_cnt_q + 32'd1;
        end
      end
      S_RUN: begin
        if (run_lim_q != '0 && run_cnt_q == run_lim_q - CNT_W'(1)) begin
          state_d = S_DONE;
        end else begin
          run_cnt_d = run_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d      = S_IDLE;
      idx_d        = '0;
      run_cnt_d    = '0;
      settle_cnt_d = '0;
      drain_d      = 1'b0;
      initialize_d = 1'b0;
      init_data_d  = init_data_q;
      init_addr_d  = init_addr_q;
      error_d      = error_q;
`ifdef BOOT_CHECKSUM_EN
      sum_d        = '0;
`endif
    end

    // All status outputs are registered images of the next state.
    cpu_rst_d = (state_d != S_RUN);
    s_ready_d = (state_d == S_LOAD) && !drain_d;
    busy_d    = (state_d == S_LOAD) || (state_d == S_SETTLE) || (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      load_cnt_q   <= '0;
      run_lim_q    <= '0;
      run_cnt_q    <= '0;
      settle_cnt_q <= '0;
      drain_q      <= 1'b0;
      init_data_q  <= '0;
      init_addr_q  <= BASE_ADDR;
      initialize_q <= 1'b0;
      cpu_rst_q    <= 1'b1;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_q        <= '0;
      exp_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      load_cnt_q   <= load_cnt_d;
      run_lim_q    <= run_lim_d;
      run_cnt_q    <= run_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      drain_q      <= drain_d;
      init_data_q  <= init_data_d;
      init_addr_q  <= init_addr_d;
      initialize_q <= initialize_d;
      cpu_rst_q    <= cpu_rst_d;
      s_ready_q    <= s_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q        <= sum_d;
      exp_q        <= exp_d;
`endif
    end
  end

  assign s.s_ready  = s_ready_q;
  assign initialize = initialize_q;
  assign init_data  = init_data_q;
  assign init_addr  = init_addr_q;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Scoreboard bench for imem_boot_sequencer: stimulus queues expected imem writes,
// a negedge monitor pops them on each initialize pulse and tracks cpu_rst timing.
module tb_imem_boot_sequencer;
  localparam int unsigned SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [7:0]  load_count;
  logic [31:0] run_limit;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] expected_sum;
`endif
  logic        initialize, cpu_rst, busy, done, error;
  logic [31:0] init_data, init_addr;

  imem_boot_sequencer_if sif();

  imem_boot_sequencer #(
    .BASE_ADDR(32'h0000_0000), .MAX_WORDS(64), .WORD_CNT_W(8),
    .SETTLE_CYCLES(SETTLE), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .load_count(load_count), .run_limit(run_limit),
`ifdef BOOT_CHECKSUM_EN
    .expected_sum(expected_sum),
`endif
    .s(sif), .initialize(initialize), .init_data(init_data), .init_addr(init_addr),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] wv [8];
  int unsigned n_cmp = 0, n_fail = 0;
  int          cyc = 0, wr_cnt = 0, low_cnt = 0;
  int          first_wr = -1, last_wr = -1, first_low = -1;
  int          k;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (!rst) begin
      if (initialize) begin
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", init_addr, init_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", init_addr, e.addr);
          chk("wr_data", init_data, e.data);
        end
      end
      if (!cpu_rst) begin
        if (first_low < 0) first_low = cyc;
        low_cnt++;
      end
    end
  end

  task automatic clear_stats();
    wr_cnt = 0; low_cnt = 0; first_wr = -1; last_wr = -1; first_low = -1;
  endtask

  task automatic do_start(input logic [7:0] n, input logic [31:0] lim);
    load_count = n; run_limit = lim; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Streams n words wv[widx..] into addresses 0,4,...; optional valid toggling.
  task automatic send(input int widx, input int n, input bit toggle);
    int i = 0, pushed = 0, budget = 0;
    bit ph = 1'b1, hs;
    while (i < n && budget < 200) begin
      if (pushed == i) begin
        exp_q.push_back(wr_t'{addr: 32'(4 * i), data: wv[widx + i]});
        pushed++;
      end
      sif.s_valid = toggle ? ph : 1'b1;
      sif.s_data  = sif.s_valid ? wv[widx + i] : 32'hDEAD_BEEF;
      @(negedge clk); hs = sif.s_valid && sif.s_ready;
      @(posedge clk); #1;
      if (hs) i++;
      ph = ~ph;
      budget++;
    end
    sif.s_valid = 1'b0;
    chk("send_words_accepted", 32'(i), 32'(n));
  endtask

  task automatic wait_done(input int budget);
    int j = 0;
    while (!done && j < budget) begin @(posedge clk); #1; j++; end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wv = '{32'h2001_0005, 32'h2002_0003, 32'h0022_1820, 32'h1111_1111,
           32'h2222_2222, 32'd1, 32'd2, 32'd3};
    rst = 1'b1; start = 1'b0; abort = 1'b0; load_count = '0; run_limit = '0;
    sif.s_valid = 1'b0; sif.s_data = '0;
`ifdef BOOT_CHECKSUM_EN
    expected_sum = '0;
`endif
    repeat (2) @(posedge clk); #1;
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_initialize", 32'(initialize), 32'd0);
    chk("rst_init_addr", init_addr, 32'h0);
    chk("rst_init_data", init_data, 32'h0);
    chk("rst_s_ready", 32'(sif.s_ready), 32'd0);
    chk("rst_busy_done_err", {29'd0, busy, done, error}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Continuous load of 3 words, run 10 cycles.
    clear_stats();
    do_start(8'd3, 32'd10);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_s_ready", 32'(sif.s_ready), 32'd1);
    send(0, 3, 1'b0);
    wait_done(100);
    chk("t1_writes", 32'(wr_cnt), 32'd3);
    chk("t1_consecutive", 32'(last_wr - first_wr), 32'd2);
    chk("t1_settle_gap", 32'(first_low - last_wr), SETTLE + 1);
    chk("t1_run_cycles", 32'(low_cnt), 32'd10);
    chk("t1_cpu_rst_after", 32'(cpu_rst), 32'd1);

    // Reload from DONE with s_valid toggling.
    clear_stats();
    do_start(8'd3, 32'd10);
    chk("t2_done_cleared", 32'(done), 32'd0);
    send(0, 3, 1'b1);
    wait_done(100);
    chk("t2_writes", 32'(wr_cnt), 32'd3);
    chk("t2_spacing", 32'(last_wr - first_wr), 32'd4);
    chk("t2_run_cycles", 32'(low_cnt), 32'd10);

    // Abort to IDLE, then an oversize load_count.
    abort = 1'b1; @(posedge clk); #1 abort = 1'b0;
    chk("t3_abort_done", 32'(done), 32'd0);
    clear_stats();
    do_start(8'd65, 32'd5);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_s_ready", 32'(sif.s_ready), 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("t3_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t3_no_writes", 32'(wr_cnt), 32'd0);

    // Valid start clears error; run until abort.
    clear_stats();
    do_start(8'd1, 32'd0);
    chk("t4_error_cleared", 32'(error), 32'd0);
    send(0, 1, 1'b0);
    k = 0;
    while (low_cnt < 50 && k < 300) begin @(posedge clk); #1; k++; end
    abort = 1'b1; @(posedge clk); #1 abort = 1'b0;
    chk("t4_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t4_busy_done", {30'd0, busy, done}, 32'd0);
    chk("t4_run_cycles", 32'(low_cnt), 32'd51);
    chk("t4_error_kept", 32'(error), 32'd0);

    // Asynchronous reset after 2 of 4 words, then reload from BASE_ADDR.
    clear_stats();
    do_start(8'd4, 32'd5);
    send(3, 2, 1'b0);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("t5_init_addr", init_addr, 32'h0);
    chk("t5_init_data", init_data, 32'h0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_s_ready", 32'(sif.s_ready), 32'd0);
    chk("t5_cpu_rst", 32'(cpu_rst), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    clear_stats();
    do_start(8'd2, 32'd3);
    send(5, 2, 1'b0);
    wait_done(100);
    chk("t5_writes", 32'(wr_cnt), 32'd2);
    chk("t5_run_cycles", 32'(low_cnt), 32'd3);

`ifdef BOOT_CHECKSUM_EN
    // Checksum mismatch (1+2+3 != 7) never releases the core.
    clear_stats();
    expected_sum = 32'd7;
    do_start(8'd3, 32'd4);
    send(5, 3, 1'b0);
    wait_done(100);
    chk("t6_error", 32'(error), 32'd1);
    chk("t6_no_run", 32'(low_cnt), 32'd0);
    clear_stats();
    expected_sum = 32'd6;
    do_start(8'd3, 32'd4);
    send(5, 3, 1'b0);
    wait_done(100);
    chk("t6_ok_error", 32'(error), 32'd0);
    chk("t6_ok_run", 32'(low_cnt), 32'd4);
`endif

    repeat (2) @(posedge clk); #1;
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
